// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory request port.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed data priority.
module mem_bus_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ireq_valid,
  input  logic [AW-1:0] ireq_addr,
  output logic          iresp_addr_ok,
  output logic          iresp_data_ok,
  output logic [31:0]   iresp_data,
  input  logic          dreq_valid,
  input  logic [AW-1:0] dreq_addr,
  input  logic [2:0]    dreq_size,
  input  logic [7:0]    dreq_strobe,
  input  logic [DW-1:0] dreq_data,
  output logic          dresp_addr_ok,
  output logic          dresp_data_ok,
  output logic [DW-1:0] dresp_data,
  output logic          mreq_valid,
  output logic          mreq_is_write,
  output logic [AW-1:0] mreq_addr,
  output logic [2:0]    mreq_size,
  output logic [7:0]    mreq_strobe,
  output logic [DW-1:0] mreq_data,
  input  logic          mresp_addr_ok,
  input  logic          mresp_data_ok,
  input  logic [DW-1:0] mresp_data,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t        state_r, state_s;
  logic          last_grant_r;   // 1'b0 = fetch, 1'b1 = data
  logic          pick_d_s;
  logic          take_i_s, take_d_s;
  logic [AW-1:0] addr_r;
  logic [2:0]    size_r;
  logic [7:0]    strobe_r;
  logic          is_write_r;
  logic [DW-1:0] data_r;

  // Winner selection when the data requester competes
  always_comb begin
    pick_d_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ireq_valid && dreq_valid) begin
      pick_d_s = (last_grant_r == 1'b0);
    end else begin
      pick_d_s = dreq_valid;
    end
`else
    pick_d_s = dreq_valid;
`endif
  end

  // Next-state and grant-edge capture strobes
  always_comb begin
    state_s  = state_r;
    take_i_s = 1'b0;
    take_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          state_s  = BUSY_D;
          take_d_s = 1'b1;
        end else if (ireq_valid) begin
          state_s  = BUSY_I;
          take_i_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mresp_data_ok) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and last-grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_d_s) begin
        last_grant_r <= 1'b1;
      end else if (take_i_s) begin
        last_grant_r <= 1'b0;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Request capture; held stable for the whole transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= {AW{1'b0}};
      size_r     <= 3'd0;
      strobe_r   <= 8'd0;
      is_write_r <= 1'b0;
      data_r     <= {DW{1'b0}};
    end else if (take_d_s) begin
      addr_r     <= dreq_addr;
      size_r     <= dreq_size;
      strobe_r   <= dreq_strobe;
      is_write_r <= |dreq_strobe;
      data_r     <= dreq_data;
    end else if (take_i_s) begin
      addr_r     <= ireq_addr;
      size_r     <= 3'd2;
      strobe_r   <= 8'd0;
      is_write_r <= 1'b0;
      data_r     <= {DW{1'b0}};
    end else begin
      addr_r     <= addr_r;
      size_r     <= size_r;
      strobe_r   <= strobe_r;
      is_write_r <= is_write_r;
      data_r     <= data_r;
    end
  end

  assign mreq_valid    = (state_r != IDLE);
  assign mreq_is_write = is_write_r;
  assign mreq_addr     = addr_r;
  assign mreq_size     = size_r;
  assign mreq_strobe   = strobe_r;
  assign mreq_data     = data_r;
  assign grant         = {state_r == BUSY_D, state_r == BUSY_I};

  // Handshakes reach only the current owner
  assign iresp_addr_ok = (state_r == BUSY_I) & mresp_addr_ok;
  assign iresp_data_ok = (state_r == BUSY_I) & mresp_data_ok;
  assign dresp_addr_ok = (state_r == BUSY_D) & mresp_addr_ok;
  assign dresp_data_ok = (state_r == BUSY_D) & mresp_data_ok;
  assign iresp_data    = addr_r[2] ? mresp_data[63:32] : mresp_data[31:0];
  assign dresp_data    = mresp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (default or MEM_ARB_ROUND_ROBIN_EN build).
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid, mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_addr_ok, mresp_data_ok;
  logic [63:0] mresp_data;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data),
    .grant(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({mreq_valid, grant, mreq_is_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {mreq_valid, grant, mreq_is_write});
    end
    checks++;
    if ({mreq_addr, mreq_data, mreq_size, mreq_strobe} !== 139'd0) begin
      errors++; $display("FAIL reset_fields: addr=%h data=%h size=%0d strb=%h want all 0",
                         mreq_addr, mreq_data, mreq_size, mreq_strobe);
    end
    rst = 1'b0;
    mresp_addr_ok = 1'b1; mresp_data_ok = 1'b1;
    #1;
    checks++;
    if ({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL idle_resp_ignored: got %b want 0000",
                         {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok});
    end
    tick();
    checks++;
    if (mreq_valid !== 1'b0) begin
      errors++; $display("FAIL idle_stays_idle: mreq_valid=%b want 0", mreq_valid);
    end
    mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0;
  endtask

  task automatic test_fetch(input logic [63:0] a, input logic [31:0] exp_word);
    ireq_valid = 1'b1; ireq_addr = a;
    #1;
    checks++;
    if (mreq_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_latency: mreq_valid=%b in request cycle want 0", mreq_valid);
    end
    tick();
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    checks++;
    if ({mreq_valid, grant, mreq_is_write, mreq_size, mreq_strobe} !== {1'b1, 2'b01, 1'b0, 3'd2, 8'h00}) begin
      errors++; $display("FAIL fetch_req: valid=%b grant=%b wr=%b size=%0d strb=%h want 1 01 0 2 00",
                         mreq_valid, grant, mreq_is_write, mreq_size, mreq_strobe);
    end
    checks++;
    if (mreq_addr !== a) begin
      errors++; $display("FAIL fetch_addr: got %h want %h", mreq_addr, a);
    end
    mresp_addr_ok = 1'b1;
    #1;
    checks++;
    if ({iresp_addr_ok, dresp_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL fetch_addr_ok: i=%b d=%b want 1 0", iresp_addr_ok, dresp_addr_ok);
    end
    tick();
    mresp_addr_ok = 1'b0;
    checks++;
    if (mreq_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_hold: mreq_valid=%b want 1", mreq_valid);
    end
    tick();
    tick();
    mresp_data = 64'h1111_2222_3333_4444; mresp_data_ok = 1'b1;
    #1;
    checks++;
    if ({iresp_data_ok, dresp_data_ok} !== 2'b10 || iresp_data !== exp_word) begin
      errors++; $display("FAIL fetch_resp: iok=%b dok=%b data=%h want 1 0 %h",
                         iresp_data_ok, dresp_data_ok, iresp_data, exp_word);
    end
    tick();
    mresp_data_ok = 1'b0;
    #1;
    checks++;
    if ({mreq_valid, grant, iresp_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL fetch_done: got %b want 0000", {mreq_valid, grant, iresp_data_ok});
    end
  endtask

  task automatic test_write();
    dreq_valid = 1'b1; dreq_addr = 64'h10; dreq_size = 3'd3;
    dreq_strobe = 8'hFF; dreq_data = 64'hDEAD_BEEF;
    tick();
    dreq_addr = 64'h20; dreq_valid = 1'b0; dreq_data = 64'h0; dreq_strobe = 8'h00;
    #1;
    checks++;
    if ({mreq_valid, grant, mreq_is_write, mreq_size, mreq_strobe} !== {1'b1, 2'b10, 1'b1, 3'd3, 8'hFF}) begin
      errors++; $display("FAIL write_req: valid=%b grant=%b wr=%b size=%0d strb=%h want 1 10 1 3 ff",
                         mreq_valid, grant, mreq_is_write, mreq_size, mreq_strobe);
    end
    checks++;
    if (mreq_data !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL write_data: got %h want deadbeef", mreq_data);
    end
    tick();
    checks++;
    if (mreq_addr !== 64'h10) begin
      errors++; $display("FAIL write_addr_stable: got %h want 10", mreq_addr);
    end
    mresp_data = 64'hCAFE_0000_0000_F00D; mresp_data_ok = 1'b1;
    #1;
    checks++;
    if ({dresp_data_ok, iresp_data_ok} !== 2'b10 || dresp_data !== 64'hCAFE_0000_0000_F00D) begin
      errors++; $display("FAIL write_resp: dok=%b iok=%b data=%h want 1 0 cafe00000000f00d",
                         dresp_data_ok, iresp_data_ok, dresp_data);
    end
    tick();
    mresp_data_ok = 1'b0;
    #1;
    checks++;
    if ({mreq_valid, dresp_data_ok} !== 2'b00) begin
      errors++; $display("FAIL write_done: valid=%b dok=%b want 0 0", mreq_valid, dresp_data_ok);
    end
  endtask

  task automatic test_reset_mid();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0008;
    tick();
    ireq_valid = 1'b0;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL midrst_setup: grant=%b want 01", grant);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mreq_valid, grant} !== 3'b000 || mreq_addr !== 64'h0) begin
      errors++; $display("FAIL midrst_drop: valid=%b grant=%b addr=%h want 0 00 0", mreq_valid, grant, mreq_addr);
    end
    tick();
    rst = 1'b0;
    mresp_data_ok = 1'b1;
    #1;
    checks++;
    if (iresp_data_ok !== 1'b0) begin
      errors++; $display("FAIL midrst_no_resp: iresp_data_ok=%b want 0", iresp_data_ok);
    end
    tick();
    mresp_data_ok = 1'b0;
    checks++;
    if (mreq_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: mreq_valid=%b want 0", mreq_valid);
    end
  endtask

  task automatic test_back_to_back();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] exp_seq [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    logic [1:0] exp_seq [4] = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    int n;
    int budget;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    n = 4;
`else
    n = 3;
`endif
    do_reset();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    dreq_valid = 1'b1; dreq_addr = 64'h40; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h0;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (grant === 2'b00 && budget < 10) begin
        tick();
        budget++;
      end
      checks++;
      if (grant !== exp_seq[k]) begin
        errors++; $display("FAIL rr_seq[%0d]: grant=%b want %b", k, grant, exp_seq[k]);
      end
      mresp_data_ok = 1'b1;
      tick();
      mresp_data_ok = 1'b0;
      checks++;
      if ({mreq_valid, grant} !== 3'b000) begin
        errors++; $display("FAIL gap[%0d]: valid=%b grant=%b want 0 00", k, mreq_valid, grant);
      end
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0; dreq_strobe = 8'h00; dreq_data = 64'h0;
    mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0; mresp_data = 64'h0;
    test_reset();
    test_fetch(64'h8000_0000, 32'h3333_4444);
    tick();
    test_fetch(64'h8000_0004, 32'h1111_2222);
    tick();
    test_write();
    tick();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
